// File: rtl/bs_packer_p_pkg.sv
// Shared types and helpers for the bs_packer_p bit-stream packer:
// FSM state enum, byte-stuffing marker constants and width helpers.
package bs_packer_p_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PAD,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [7:0] MARK_FF = 8'hFF;
    localparam logic [7:0] MARK_00 = 8'h00;

    // Bits needed to hold any value 0..max_val
    function automatic int len_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/bs_packer_p_byte_fifo.sv
// bs_byte_fifo: synchronous DEPTH x 8 byte FIFO with full/empty/count,
// read data presented combinationally from the head entry.
module bs_byte_fifo
    import bs_packer_p_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_push,
    input  logic [7:0]              i_data,
    input  logic                    i_pop,
    output logic [7:0]              o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [ptr_w(DEPTH):0]   o_count
);
    localparam int PW = ptr_w(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bs_packer_p.sv
// bs_packer_p: packs variable-length codes MSB-first into a byte stream, pads
// frames with one-bits on flush. Optional macro BS_PACKER_STUFF_EN inserts 0x00 after 0xFF.
module bs_packer_p
    import bs_packer_p_pkg::*;
#(
    parameter int W_IN  = 32,
    parameter int DEPTH = 16,
    parameter int W_CNT = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W_IN-1:0]        in_data,
    input  logic [len_w(W_IN)-1:0] in_len,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic                   frame_done,
    output logic [W_CNT-1:0]       frame_bytes
);
    localparam int AW  = 2 * W_IN;
    localparam int LW  = len_w(W_IN);
    localparam int ALW = len_w(AW);
    localparam int CW  = ptr_w(DEPTH) + 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [AW-1:0]    r_acc;
    logic [ALW-1:0]   r_acc_len;
    logic             r_stuff_pend;
    logic             r_run_en;
    logic [W_CNT-1:0] r_frame_bytes;

    logic             w_full, w_empty, w_push, w_pop;
    logic             w_accept, w_extract, w_stuff_push, w_stuff_hit;
    logic [7:0]       w_push_data, w_fifo_dout;
    logic [CW-1:0]    w_count;
    logic [2:0]       w_pad;
    logic [LW-1:0]    w_app_len;
    logic [W_IN-1:0]  w_app_data, w_app_code;
    logic [AW-1:0]    w_app_top, w_acc_sh;
    logic [ALW-1:0]   w_len_sh;

    assign in_ready     = r_run_en && (r_state == ST_RUN) && (r_acc_len <= ALW'(W_IN));
    assign w_accept     = in_valid && in_ready;
    assign w_stuff_push = r_stuff_pend && !w_full;
    assign w_extract    = !r_stuff_pend && !w_full && (r_acc_len >= ALW'(8));
    assign w_push       = w_stuff_push || w_extract;
    assign w_push_data  = r_stuff_pend ? MARK_00 : r_acc[AW-1 -: 8];
    assign w_pop        = out_valid && out_ready;
`ifdef BS_PACKER_STUFF_EN
    assign w_stuff_hit  = w_extract && (r_acc[AW-1 -: 8] == MARK_FF);
`else
    assign w_stuff_hit  = 1'b0;
`endif

    // Padding and codes share one append path: mask, MSB-align, then slot in below the occupied bits
    assign w_pad      = 3'(4'd8 - {1'b0, r_acc_len[2:0]});
    assign w_app_len  = w_accept ? in_len : ((r_state == ST_PAD) ? LW'(w_pad) : '0);
    assign w_app_data = w_accept ? in_data : '1;
    assign w_app_code = w_app_data & ~({W_IN{1'b1}} << w_app_len);
    assign w_app_top  = {w_app_code, {W_IN{1'b0}}} << (LW'(W_IN) - w_app_len);
    assign w_acc_sh   = w_extract ? (r_acc << 8) : r_acc;
    assign w_len_sh   = w_extract ? (r_acc_len - ALW'(8)) : r_acc_len;

    assign out_valid   = !w_empty;
    assign out_data    = w_empty ? 8'h00 : w_fifo_dout;
    assign frame_done  = (r_state == ST_DONE);
    assign frame_bytes = r_frame_bytes;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN:   if (flush && r_run_en) w_state_nxt = ST_PAD;
            ST_PAD:   w_state_nxt = ST_DRAIN;
            // Leave as soon as the last byte is being popped so frame_done follows it by one cycle
            ST_DRAIN: if ((r_acc_len == '0) && !r_stuff_pend &&
                          (w_empty || ((w_count == CW'(1)) && w_pop)))
                          w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_RUN;
            r_acc         <= '0;
            r_acc_len     <= '0;
            r_stuff_pend  <= 1'b0;
            r_run_en      <= 1'b0;
            r_frame_bytes <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_run_en     <= 1'b1;
            r_acc        <= w_acc_sh | (w_app_top >> w_len_sh);
            r_acc_len    <= w_len_sh + ALW'(w_app_len);
            r_stuff_pend <= w_stuff_hit || (r_stuff_pend && w_full);
            if (r_state == ST_DONE) begin
                r_frame_bytes <= '0;
            end else if (w_pop && (r_frame_bytes != '1)) begin
                r_frame_bytes <= r_frame_bytes + W_CNT'(1);
            end
        end
    end

    bs_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule
